// File: rtl/trace_capture.sv
// Single-channel logic-analyser trace capture. Samples a synchronised input at a
// fixed divided rate after a trigger and hands the finished trace to the display only on frame starts.
module trace_capture #(
    parameter int DATA_SIZE  = 256,
    parameter int SAMPLE_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 arm,
    input  logic [1:0]           trig_mode,
    input  logic                 continuous,
    input  logic                 frame_start,
    output logic [DATA_SIZE-1:0] data,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(DATA_SIZE + 1);
    localparam int DW = $clog2(SAMPLE_DIV + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_SIZE - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic                 s_meta_r;
    logic                 s_sync_r;
    logic                 s_prev_r;
    logic [CW-1:0]        cnt_r;
    logic [DW-1:0]        div_r;
    logic [DATA_SIZE-1:0] capture_buf_r;
    logic                 pending_r;
    logic [DATA_SIZE-1:0] data_r;

    logic                 trig_hit_s;
    logic                 start_s;
    logic                 sample_s;
    logic                 finish_s;
    logic                 transfer_s;

    // Trigger qualification from the synchronised signal and its delayed copy.
    always_comb begin
        trig_hit_s = 1'b0;
        case (trig_mode)
            2'b00:   trig_hit_s = 1'b1;
            2'b01:   trig_hit_s = s_sync_r & ~s_prev_r;
            2'b10:   trig_hit_s = ~s_sync_r & s_prev_r;
            2'b11:   trig_hit_s = s_sync_r ^ s_prev_r;
            default: trig_hit_s = 1'b0;
        endcase
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        sample_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    next_state_s = ST_WAIT_TRIG;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_TRIG: begin
                if (trig_hit_s) begin
                    start_s      = 1'b1;
                    next_state_s = ST_CAPTURE;
                end else begin
                    next_state_s = ST_WAIT_TRIG;
                end
            end
            ST_CAPTURE: begin
                if (div_r == DIV_LAST) begin
                    sample_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        finish_s     = 1'b1;
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_CAPTURE;
                    end
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (arm || continuous) begin
                    next_state_s = ST_WAIT_TRIG;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign transfer_s = frame_start & pending_r;
    assign busy       = (state_r == ST_WAIT_TRIG) || (state_r == ST_CAPTURE);
    assign done       = (state_r == ST_DONE);
    assign data       = data_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Two-flop synchroniser plus the delayed copy used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_meta_r <= 1'b0;
            s_sync_r <= 1'b0;
            s_prev_r <= 1'b0;
        end else begin
            s_meta_r <= sig_in;
            s_sync_r <= s_meta_r;
            s_prev_r <= s_sync_r;
        end
    end

    // Sample shift register, sample counter and rate divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capture_buf_r <= '0;
            cnt_r         <= '0;
            div_r         <= '0;
        end else begin
            if (start_s || sample_s) begin
                capture_buf_r <= {s_sync_r, capture_buf_r[DATA_SIZE-1:1]};
            end
            if (start_s) begin
                cnt_r <= CNT_ONE;
                div_r <= '0;
            end else if (sample_s) begin
                cnt_r <= cnt_r + CNT_ONE;
                div_r <= '0;
            end else if (state_r == ST_CAPTURE) begin
                div_r <= div_r + DIV_ONE;
            end
        end
    end

    // Completion wins over a same-cycle frame start, so the hand-off waits a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
            data_r    <= '0;
        end else begin
            if (finish_s) begin
                pending_r <= 1'b1;
            end else if (start_s || transfer_s) begin
                pending_r <= 1'b0;
            end
            if (transfer_s) begin
                data_r <= capture_buf_r;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with DATA_SIZE=8, SAMPLE_DIV=2.
module tb_trace_capture;

    logic       clk;
    logic       reset;
    logic       sig_in;
    logic       arm;
    logic [1:0] trig_mode;
    logic       continuous;
    logic       frame_start;
    logic [7:0] data;
    logic       busy;
    logic       done;

    int pass_cnt;
    int total_cnt;
    int n;

    trace_capture #(
        .DATA_SIZE (8),
        .SAMPLE_DIV(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .continuous (continuous),
        .frame_start(frame_start),
        .data       (data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Ticks until done rises, returning the number of edges taken (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done && cycles < 60);
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        reset       = 1'b0;
        sig_in      = 1'b0;
        arm         = 1'b0;
        trig_mode   = 2'b00;
        continuous  = 1'b0;
        frame_start = 1'b0;
        #2 reset = 1'b1;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data", 32'(data), 32'h00);
        reset = 1'b0;
        tick();
        tick();
        tick();

        // Immediate trigger: samples 0-3 low, 4-7 high.
        pulse_arm();
        check("imm_busy_wait", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        sig_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("imm_not_done_yet", 32'(done), 32'd0);
        tick();
        check("imm_done_15clk", 32'(done), 32'd1);
        check("imm_data_held", 32'(data), 32'h00);
        pulse_frame();
        check("imm_data", 32'(data), 32'hF0);
        check("imm_stays_done", 32'(done), 32'd1);

        // Rising edge mode, no edge while low.
        trig_mode = 2'b01;
        sig_in    = 1'b0;
        tick(); tick(); tick();
        pulse_arm();
        for (int i = 0; i < 4; i++) tick();
        check("rise_waiting_busy", 32'(busy), 32'd1);
        check("rise_waiting_done", 32'(done), 32'd0);
        sig_in = 1'b1;
        wait_done(n);
        check("rise_latency", 32'(n), 32'd17);
        pulse_frame();
        check("rise_data", 32'(data), 32'hFF);

        // Held high with no edge: no trigger.
        pulse_arm();
        for (int i = 0; i < 20; i++) tick();
        check("held_busy", 32'(busy), 32'd1);
        check("held_done", 32'(done), 32'd0);
        pulse_frame();
        check("held_data", 32'(data), 32'hFF);

        // Falling edge releases the waiting capture.
        trig_mode = 2'b10;
        sig_in    = 1'b0;
        wait_done(n);
        check("fall_latency", 32'(n), 32'd17);
        pulse_frame();
        check("fall_data", 32'(data), 32'h00);

        // Either edge, completion coincident with frame_start.
        trig_mode = 2'b11;
        pulse_arm();
        tick(); tick();
        check("either_waiting", 32'(busy), 32'd1);
        sig_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        sig_in = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("either_not_done", 32'(done), 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("either_done", 32'(done), 32'd1);
        check("coincident_data_unchanged", 32'(data), 32'h00);
        pulse_frame();
        check("coincident_data_next_frame", 32'(data), 32'h03);

        // Continuous mode: second result overwrites the first.
        trig_mode  = 2'b00;
        continuous = 1'b1;
        pulse_arm();
        for (int i = 0; i < 15; i++) tick();
        check("cont_done_1", 32'(done), 32'd1);
        sig_in = 1'b1;
        tick();
        check("cont_rearm_done", 32'(done), 32'd0);
        check("cont_rearm_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("cont_done_2", 32'(done), 32'd1);
        check("cont_data_held", 32'(data), 32'h03);
        continuous = 1'b0;
        tick();
        check("cont_stop_done", 32'(done), 32'd1);
        pulse_frame();
        check("cont_latest_data", 32'(data), 32'hFE);

        // Reset mid-capture.
        pulse_arm();
        tick(); tick(); tick();
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_data", 32'(data), 32'h00);
        tick();
        reset = 1'b0;
        tick();
        pulse_frame();
        tick();
        check("rst_after_frame_data", 32'(data), 32'h00);
        check("rst_after_busy", 32'(busy), 32'd0);
        check("rst_after_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
